cpu_trace_checker: RTL and testbench

Streaming, byte-per-cycle checker for single-cycle CPU trace lines. It parses register-write lines (`^T@PPPPPPPP: $G <= DDDDDDDD#`) and memory-write lines (`^T@PPPPPPPP: *AAAAAAAA <= DDDDDDDD#`), then flags timing, PC, address and register-index violations. Address windows, register count, time-digit limit and hex case are parametrised. It also adds decoded-field outputs and saturating line and error counters. It sits between the testbench char source and the scoreboard in the CPU verification harness.

---
 rtl/cpu_checker_pkg.sv | 32 +++
 rtl/cpu_trace_checker_if.sv | 28 ++
 rtl/trace_field_check.sv | 36 +++
 rtl/cpu_trace_checker.sv | 195 +++++++++++++++++++
 tb/tb_cpu_trace_checker.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_checker_pkg.sv
// Shared types, codes and character-class helpers for the CPU trace checker.
package cpu_checker_pkg;

  typedef enum logic [3:0] {
    IDLE, TIME, AT, PC, COLON_SP, GRF, ADDR, PRE_LT, EQ, DATA_SP, DATA, DONE_R, DONE_M
  } state_t;

  localparam logic [1:0] FMT_NONE = 2'b00;
  localparam logic [1:0] FMT_REG  = 2'b01;
  localparam logic [1:0] FMT_MEM  = 2'b10;

  localparam int ERR_TIME = 0;
  localparam int ERR_PC   = 1;
  localparam int ERR_ADDR = 2;
  localparam int ERR_GRF  = 3;

  function automatic logic is_dec(input logic [7:0] c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction

  function automatic logic is_hex(input logic [7:0] c, input logic upper);
    return is_dec(c) || ((c >= 8'h61) && (c <= 8'h66)) ||
           (upper && (c >= 8'h41) && (c <= 8'h46));
  endfunction

  // Letters 'a'/'A' have low nibble 1, so +9 maps both cases onto 10..15.
  function automatic logic [3:0] hex_val(input logic [7:0] c);
    if (is_dec(c)) return c[3:0];
    return c[3:0] + 4'd9;
  endfunction

endpackage

// File: rtl/cpu_trace_checker_if.sv
// Character stream in, decoded-line results out, plus the parser state for observation.
interface cpu_trace_checker_if #(parameter int CNT_W = 16);
  import cpu_checker_pkg::*;

  // Stream contract: no valid/ready; the source presents one byte on char every
  // clock and the checker always consumes it, so there is never backpressure.
  logic [7:0]       char;
  logic [15:0]      freq;
  logic [1:0]       format_type;
  logic [3:0]       error_code;
  logic [31:0]      rec_pc;
  logic [31:0]      rec_idx;
  logic [31:0]      rec_data;
  logic [CNT_W-1:0] line_cnt;
  logic [CNT_W-1:0] err_cnt;
  state_t           state;

  modport master (
    output char, freq,
    input  format_type, error_code, rec_pc, rec_idx, rec_data, line_cnt, err_cnt, state
  );

  modport slave (
    input  char, freq,
    output format_type, error_code, rec_pc, rec_idx, rec_data, line_cnt, err_cnt, state
  );

endinterface

// File: rtl/trace_field_check.sv
// Combinational range, alignment and period checks on one decoded trace line.
module trace_field_check
  import cpu_checker_pkg::*;
#(
  parameter int          GRF_NUM = 32,
  parameter logic [31:0] PC_LO   = 32'h0000_3000,
  parameter logic [31:0] PC_HI   = 32'h0000_4fff,
  parameter logic [31:0] ADDR_LO = 32'h0000_0000,
  parameter logic [31:0] ADDR_HI = 32'h0000_2fff
) (
  input  logic [31:0] time_val,
  input  logic [15:0] freq,
  input  logic [31:0] pc,
  input  logic [31:0] idx,
  input  logic        is_mem,
  output logic [3:0]  error_code
);

  // Offset compare: below-range values wrap to a huge offset and fail too.
  function automatic logic in_range(input logic [31:0] v, input logic [31:0] lo,
                                    input logic [31:0] hi);
    return (v - lo) <= (hi - lo);
  endfunction

  logic [31:0] period_mask;
  assign period_mask = ({16'd0, freq} >> 1) - 32'd1;

  always_comb begin
    error_code           = '0;
    error_code[ERR_TIME] = (time_val != 32'd0) && ((time_val & period_mask) != 32'd0);
    error_code[ERR_PC]   = !in_range(pc, PC_LO, PC_HI) || (pc[1:0] != 2'b00);
    error_code[ERR_GRF]  = !is_mem && (idx >= 32'(GRF_NUM));
    error_code[ERR_ADDR] = is_mem && (!in_range(idx, ADDR_LO, ADDR_HI) || (idx[1:0] != 2'b00));
  end

endmodule

// File: rtl/cpu_trace_checker.sv
// Byte-per-cycle parser for register/memory-write trace lines with result pulse and counters.
module cpu_trace_checker
  import cpu_checker_pkg::*;
#(
  parameter int          TIME_DIGITS = 4,
  parameter int          GRF_NUM     = 32,
  parameter logic [31:0] PC_LO       = 32'h0000_3000,
  parameter logic [31:0] PC_HI       = 32'h0000_4fff,
  parameter logic [31:0] ADDR_LO     = 32'h0000_0000,
  parameter logic [31:0] ADDR_HI     = 32'h0000_2fff,
  parameter bit          HEX_UPPER   = 1'b0,
  parameter int          CNT_W       = 16
) (
  input logic               clk,
  input logic               reset,
  cpu_trace_checker_if.slave bus
);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] time_q, time_d, pc_q, pc_d, idx_q, idx_d, data_q, data_d;
  logic        mem_q, mem_d;
  logic        done_line;

  logic [7:0]  c;
  logic        c_dec, c_hex;
  logic [3:0]  c_hv;
  logic [3:0]  chk_err;

  logic [1:0]       fmt_q;
  logic [3:0]       err_q;
  logic [31:0]      rec_pc_q, rec_idx_q, rec_data_q;
  logic [CNT_W-1:0] line_cnt_q, err_cnt_q;

  assign c     = bus.char;
  assign c_dec = is_dec(c);
  assign c_hex = is_hex(c, HEX_UPPER);
  assign c_hv  = hex_val(c);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    time_d    = time_q;
    pc_d      = pc_q;
    idx_d     = idx_q;
    data_d    = data_q;
    mem_d     = mem_q;
    done_line = 1'b0;
    if (c == "^") begin
      state_d = TIME;
      cnt_d   = '0;
      time_d  = '0;
      pc_d    = '0;
      idx_d   = '0;
      data_d  = '0;
      mem_d   = 1'b0;
    end else begin
      // Every byte not explicitly accepted below abandons the line.
      state_d = IDLE;
      case (state_q)
        TIME:
          if (c_dec && (cnt_q < 4'(TIME_DIGITS))) begin
            state_d = TIME;
            time_d  = time_q * 32'd10 + {28'd0, c[3:0]};
            cnt_d   = cnt_q + 4'd1;
          end else if ((c == "@") && (cnt_q != 4'd0)) begin
            state_d = AT;
            cnt_d   = '0;
          end
        AT:
          if (c_hex) begin
            state_d = PC;
            pc_d    = {pc_q[27:0], c_hv};
            cnt_d   = 4'd1;
          end
        PC:
          if (c_hex && (cnt_q < 4'd8)) begin
            state_d = PC;
            pc_d    = {pc_q[27:0], c_hv};
            cnt_d   = cnt_q + 4'd1;
          end else if ((c == ":") && (cnt_q == 4'd8)) begin
            state_d = COLON_SP;
          end
        COLON_SP:
          if (c == " ") state_d = COLON_SP;
          else if (c == "$") begin
            state_d = GRF;
            cnt_d   = '0;
            mem_d   = 1'b0;
          end else if (c == "*") begin
            state_d = ADDR;
            cnt_d   = '0;
            mem_d   = 1'b1;
          end
        GRF:
          if (c_dec && (cnt_q < 4'd4)) begin
            state_d = GRF;
            idx_d   = idx_q * 32'd10 + {28'd0, c[3:0]};
            cnt_d   = cnt_q + 4'd1;
          end else if ((cnt_q != 4'd0) && (c == " ")) state_d = PRE_LT;
          else if ((cnt_q != 4'd0) && (c == "<")) state_d = EQ;
        ADDR:
          if (c_hex && (cnt_q < 4'd8)) begin
            state_d = ADDR;
            idx_d   = {idx_q[27:0], c_hv};
            cnt_d   = cnt_q + 4'd1;
          end else if ((cnt_q == 4'd8) && (c == " ")) state_d = PRE_LT;
          else if ((cnt_q == 4'd8) && (c == "<")) state_d = EQ;
        PRE_LT:
          if (c == " ") state_d = PRE_LT;
          else if (c == "<") state_d = EQ;
        EQ:
          if (c == "=") state_d = DATA_SP;
        DATA_SP:
          if (c == " ") state_d = DATA_SP;
          else if (c_hex) begin
            state_d = DATA;
            data_d  = {data_q[27:0], c_hv};
            cnt_d   = 4'd1;
          end
        DATA:
          if (c_hex && (cnt_q < 4'd8)) begin
            state_d = DATA;
            data_d  = {data_q[27:0], c_hv};
            cnt_d   = cnt_q + 4'd1;
          end else if ((c == "#") && (cnt_q == 4'd8)) begin
            state_d   = mem_q ? DONE_M : DONE_R;
            done_line = 1'b1;
          end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      time_q  <= '0;
      pc_q    <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      mem_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      time_q  <= time_d;
      pc_q    <= pc_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      mem_q   <= mem_d;
    end
  end

  trace_field_check #(
    .GRF_NUM(GRF_NUM), .PC_LO(PC_LO), .PC_HI(PC_HI), .ADDR_LO(ADDR_LO), .ADDR_HI(ADDR_HI)
  ) u_check (
    .time_val(time_q), .freq(bus.freq), .pc(pc_q), .idx(idx_q), .is_mem(mem_q),
    .error_code(chk_err)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fmt_q      <= FMT_NONE;
      err_q      <= '0;
      rec_pc_q   <= '0;
      rec_idx_q  <= '0;
      rec_data_q <= '0;
      line_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      fmt_q <= FMT_NONE;
      err_q <= '0;
      if (done_line) begin
        fmt_q      <= mem_q ? FMT_MEM : FMT_REG;
        err_q      <= chk_err;
        rec_pc_q   <= pc_q;
        rec_idx_q  <= idx_q;
        rec_data_q <= data_q;
        if (line_cnt_q != '1) line_cnt_q <= line_cnt_q + CNT_W'(1);
        if ((chk_err != 4'd0) && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.format_type = fmt_q;
  assign bus.error_code  = err_q;
  assign bus.rec_pc      = rec_pc_q;
  assign bus.rec_idx     = rec_idx_q;
  assign bus.rec_data    = rec_data_q;
  assign bus.line_cnt    = line_cnt_q;
  assign bus.err_cnt     = err_cnt_q;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_cpu_trace_checker.sv
// Directed trace lines plus randomized lines scored against a field-level model on two configurations.
module tb_cpu_trace_checker;
  import cpu_checker_pkg::*;

  localparam int TD = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [7:0]  char_r = 8'h00;
  logic [15:0] freq_r = 16'd4;

  cpu_trace_checker_if #(.CNT_W(16)) bus0 ();
  cpu_trace_checker_if #(.CNT_W(2))  bus1 ();
  assign bus0.char = char_r;
  assign bus0.freq = freq_r;
  assign bus1.char = char_r;
  assign bus1.freq = freq_r;

  cpu_trace_checker #(.HEX_UPPER(1'b0), .CNT_W(16)) dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));
  cpu_trace_checker #(.HEX_UPPER(1'b1), .CNT_W(2))  dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    char_r = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  // ---------------- line generator ----------------
  logic [7:0]  line_q[$];
  logic [7:0]  stim_q[$];
  logic [5:0]  exp_q0[$];
  logic [5:0]  exp_q1[$];
  int unsigned tval, pc, idx, data;
  bit          is_mem, bad_struct, trunc, up, has_upper;

  function automatic int unsigned pow10(input int n);
    int unsigned r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  task automatic push_dec(input int unsigned v, input int n);
    for (int i = n - 1; i >= 0; i--) line_q.push_back(8'(32'h30 + (v / pow10(i)) % 10));
  endtask

  task automatic push_hex(input logic [31:0] v, input int n, input bit upc);
    logic [31:0] nib;
    for (int i = n - 1; i >= 0; i--) begin
      nib = (i >= 8) ? 32'd0 : ((v >> (4 * i)) & 32'hf);
      if (nib < 10) line_q.push_back(8'(32'h30 + nib));
      else line_q.push_back(8'((upc ? 32'h41 : 32'h61) + nib - 10));
    end
  endtask

  task automatic push_sp();
    int n = $urandom_range(0, 2);
    for (int i = 0; i < n; i++) line_q.push_back(8'h20);
  endtask

  function automatic int hex_len();
    if ($urandom_range(0, 15) == 0) return ($urandom_range(0, 1) == 0) ? 7 : 9;
    return 8;
  endfunction

  task automatic gen_line();
    int tn, n, nd;
    int unsigned half;
    line_q.delete();
    bad_struct = 0;
    trunc = 0;
    up = ($urandom_range(0, 4) == 0);
    is_mem = $urandom_range(0, 1);
    freq_r = 16'(1 << $urandom_range(1, 6));
    half = freq_r / 2;
    tn = $urandom_range(1, TD);
    if ($urandom_range(0, 11) == 0) begin tn = TD + 1; bad_struct = 1; end
    case ($urandom_range(0, 2))
      0: tval = 0;
      1: tval = half * $urandom_range(0, 50);
      default: tval = $urandom_range(0, pow10(tn) - 1);
    endcase
    tval = tval % pow10(tn);
    pc = ($urandom_range(0, 3) == 0) ? $urandom() : 32'h2ff8 + 4 * $urandom_range(0, 32'h803);
    if ($urandom_range(0, 4) == 0) pc = pc + $urandom_range(1, 3);
    data = $urandom();

    line_q.push_back("^");
    push_dec(tval, tn);
    line_q.push_back("@");
    n = hex_len();
    if (n != 8) bad_struct = 1;
    push_hex(pc, n, up);
    line_q.push_back(":");
    push_sp();
    if (!is_mem) begin
      idx = $urandom_range(0, 40);
      nd = (idx >= 10) ? 2 : 1;
      n = $urandom_range(nd, 4);
      if ($urandom_range(0, 11) == 0) begin n = 5; bad_struct = 1; end
      line_q.push_back("$");
      push_dec(idx, n);
    end else begin
      idx = ($urandom_range(0, 3) == 0) ? $urandom() : 4 * $urandom_range(0, 32'hc04);
      if ($urandom_range(0, 4) == 0) idx = idx + $urandom_range(1, 3);
      n = hex_len();
      if (n != 8) bad_struct = 1;
      line_q.push_back("*");
      push_hex(idx, n, up);
    end
    push_sp();
    line_q.push_back("<");
    if ($urandom_range(0, 19) == 0) begin line_q.push_back(" "); bad_struct = 1; end
    line_q.push_back("=");
    push_sp();
    n = hex_len();
    if (n != 8) bad_struct = 1;
    push_hex(data, n, up);
    line_q.push_back("#");
    if ($urandom_range(0, 9) == 0) begin
      trunc = 1;
      n = $urandom_range(1, line_q.size() - 1);
      while (line_q.size() > n) void'(line_q.pop_back());
    end
    has_upper = 0;
    foreach (line_q[i]) if (line_q[i] >= 8'h41 && line_q[i] <= 8'h46) has_upper = 1;
  endtask

  // ---------------- reference model state ----------------
  int unsigned m_lines0, m_errs0, m_lines1, m_errs1;
  logic [31:0] m_pc0, m_idx0, m_data0, m_pc1, m_idx1, m_data1;

  function automatic logic [3:0] model_err();
    bit e_time, e_pc, e_grf, e_addr;
    e_time = !(tval == 0 || (tval % (freq_r / 2)) == 0);
    e_pc   = (pc < 32'h3000) || (pc > 32'h4fff) || (pc % 4 != 0);
    e_grf  = !is_mem && (idx >= 32);
    e_addr = is_mem && ((idx > 32'h2fff) || (idx % 4 != 0));
    return {e_grf, e_addr, e_pc, e_time};
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    logic [5:0] e0, e1, res;
    logic [3:0] err;
    bit legal0, legal1;
    logic [7:0] g;

    repeat (2) @(posedge clk);
    #1;
    check("reset_fmt", bus0.format_type, 0);
    check("reset_err", bus0.error_code, 0);
    check("reset_lines", bus0.line_cnt, 0);
    check("reset_pc", bus0.rec_pc, 0);
    check("reset_state", bus0.state, IDLE);
    @(negedge clk);
    reset = 1'b0;

    freq_r = 16'd4;
    send_str("^10@00003000: $1 <= 0000000a#");
    check("t1_fmt", bus0.format_type, 1);
    check("t1_err", bus0.error_code, 0);
    check("t1_idx", bus0.rec_idx, 1);
    check("t1_pc", bus0.rec_pc, 32'h3000);
    check("t1_data", bus0.rec_data, 32'ha);
    check("t1_lines", bus0.line_cnt, 1);
    send_byte(" ");
    check("t1_pulse_end", bus0.format_type, 0);

    send_str("^3@00003002: *00003000 <= 12345678#");
    check("t2_fmt", bus0.format_type, 2);
    check("t2_err", bus0.error_code, 4'b0111);
    check("t2_errcnt", bus0.err_cnt, 1);
    check("t2_idx", bus0.rec_idx, 32'h3000);
    check("t2_data", bus0.rec_data, 32'h12345678);

    send_str("^8@00003004: $32 <= 00000000#");
    check("t3_fmt", bus0.format_type, 1);
    check("t3_err", bus0.error_code, 4'b1000);
    send_str("^8@00003004: $031 <= 00000000#");
    check("t3b_err", bus0.error_code, 0);
    check("t3b_idx", bus0.rec_idx, 31);
    check("t3b_lines", bus0.line_cnt, 4);

    send_str("^12345@00003000: $1 <= 00000000#");
    check("t4_fmt", bus0.format_type, 0);
    send_str("^1@0003000: $1 <= 00000000#");
    check("t4b_fmt", bus0.format_type, 0);
    check("t4_lines", bus0.line_cnt, 4);
    check("t4_errcnt", bus0.err_cnt, 2);

    send_str("^5@0000300");
    send_str("^0@00003000:*00000000<=00000000#");
    check("t5_fmt", bus0.format_type, 2);
    check("t5_err", bus0.error_code, 0);
    check("t5_lines", bus0.line_cnt, 5);

    send_str("^0@0000300C: $1 <= 00000000#");
    check("t6_fmt0", bus0.format_type, 0);
    check("t6_lines0", bus0.line_cnt, 5);
    check("t6_fmt1", bus1.format_type, 1);
    check("t6_err1", bus1.error_code, 0);
    check("t6_pc1", bus1.rec_pc, 32'h300c);
    check("t6_sat_lines1", bus1.line_cnt, 3);
    check("t6_errcnt1", bus1.err_cnt, 2);

    send_str("^2@00003000: $2 <= 00000001#");
    check("rst_pre_fmt", bus0.format_type, 1);
    #2 reset = 1'b1;
    #1;
    check("rst_fmt", bus0.format_type, 0);
    check("rst_lines0", bus0.line_cnt, 0);
    check("rst_lines1", bus1.line_cnt, 0);
    check("rst_pc", bus0.rec_pc, 0);
    check("rst_state", bus0.state, IDLE);
    @(negedge clk);
    reset = 1'b0;
    send_str("^2@00003000: $2 <= 0000000");
    #2 reset = 1'b1;
    #1 reset = 1'b0;
    send_str("1#");
    check("rst_mid_fmt", bus0.format_type, 0);
    check("rst_mid_lines", bus0.line_cnt, 0);

    // Random phase starts from a clean reset so the model counters begin at zero.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_lines0 = 0; m_errs0 = 0; m_lines1 = 0; m_errs1 = 0;
    m_pc0 = 0; m_idx0 = 0; m_data0 = 0; m_pc1 = 0; m_idx1 = 0; m_data1 = 0;

    for (int n = 0; n < 300; n++) begin
      gen_line();
      legal0 = !bad_struct && !trunc && !has_upper;
      legal1 = !bad_struct && !trunc;
      err = model_err();
      res = {(is_mem ? 2'b10 : 2'b01), err};
      stim_q.delete();
      foreach (line_q[i]) begin
        stim_q.push_back(line_q[i]);
        exp_q0.push_back((i == line_q.size() - 1 && legal0) ? res : 6'd0);
        exp_q1.push_back((i == line_q.size() - 1 && legal1) ? res : 6'd0);
      end
      if (!trunc) begin
        for (int k = $urandom_range(0, 2); k > 0; k--) begin
          g = 8'($urandom_range(32, 126));
          if (g == "^") g = "_";
          stim_q.push_back(g);
          exp_q0.push_back(6'd0);
          exp_q1.push_back(6'd0);
        end
      end
      foreach (stim_q[i]) begin
        send_byte(stim_q[i]);
        e0 = exp_q0.pop_front();
        e1 = exp_q1.pop_front();
        check("rnd_fmt0", bus0.format_type, e0[5:4]);
        check("rnd_err0", bus0.error_code, e0[3:0]);
        check("rnd_fmt1", bus1.format_type, e1[5:4]);
        check("rnd_err1", bus1.error_code, e1[3:0]);
      end
      if (legal0) begin
        m_lines0++;
        if (err != 0) m_errs0++;
        m_pc0 = pc; m_idx0 = idx; m_data0 = data;
      end
      if (legal1) begin
        if (m_lines1 < 3) m_lines1++;
        if (err != 0 && m_errs1 < 3) m_errs1++;
        m_pc1 = pc; m_idx1 = idx; m_data1 = data;
      end
      check("rnd_lines0", bus0.line_cnt, m_lines0);
      check("rnd_errs0", bus0.err_cnt, m_errs0);
      check("rnd_pc0", bus0.rec_pc, m_pc0);
      check("rnd_idx0", bus0.rec_idx, m_idx0);
      check("rnd_data0", bus0.rec_data, m_data0);
      check("rnd_lines1", bus1.line_cnt, m_lines1);
      check("rnd_errs1", bus1.err_cnt, m_errs1);
      check("rnd_pc1", bus1.rec_pc, m_pc1);
      check("rnd_idx1", bus1.rec_idx, m_idx1);
      check("rnd_data1", bus1.rec_data, m_data1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
